bpu_ras: RTL

BPU_RAS -- requirements
Module: bpu_ras

---
 rtl/bpu_ras.sv | 115 +++++++++++
 1 files changed

// File: rtl/bpu_ras.sv
// Return address stack for the branch prediction unit.
// Speculative push/pop with checkpoint-based misprediction repair.
module bpu_ras #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [31:0]            push_addr_i,
    input  logic                   pop_i,
    output logic [31:0]            top_o,
    output logic                   top_valid_o,
    output logic [2*PTR_W+32:0]    ckpt_o,
    input  logic                   restore_i,
    input  logic [2*PTR_W+32:0]    restore_ckpt_i,
    input  logic [1:0]             restore_op_i,
    input  logic [31:0]            restore_addr_i,
    output logic [PTR_W:0]         count_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int            CKPT_W = 2 * PTR_W + 33;
    localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

    logic [31:0]      mem [DEPTH];

    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [PTR_W-1:0] ck_sp;
    logic [PTR_W:0]   ck_cnt;
    logic [31:0]      ck_top;

    logic [PTR_W-1:0] base_sp;
    logic [PTR_W:0]   base_cnt;
    logic             do_push;
    logic             do_pop;
    logic [31:0]      wr_data;
    logic             repair_en;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;

    // Resolve the starting state and operation, then the next state.
    always_comb begin
        ck_sp     = restore_ckpt_i[CKPT_W-1 -: PTR_W];
        ck_cnt    = restore_ckpt_i[32 +: PTR_W+1];
        ck_top    = restore_ckpt_i[31:0];
        base_sp   = restore_i ? ck_sp  : sp_q;
        base_cnt  = restore_i ? ck_cnt : count_q;
        do_push   = restore_i ? (restore_op_i == 2'b01) : push_i;
        do_pop    = restore_i ? (restore_op_i == 2'b10) : pop_i;
        wr_data   = restore_i ? restore_addr_i : push_addr_i;
        repair_en = restore_i;
        wr_en     = 1'b0;
        wr_addr   = base_sp;
        sp_d      = base_sp;
        count_d   = base_cnt;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        if (do_push && do_pop && (base_cnt != '0)) begin
            wr_en = 1'b1;
        end else if (do_push) begin
            wr_en   = 1'b1;
            wr_addr = base_sp + PTR_W'(1);
            sp_d    = base_sp + PTR_W'(1);
            if (base_cnt == FULL) begin
                ovf_d = 1'b1;
            end else begin
                count_d = base_cnt + 1'b1;
            end
        end else if (do_pop) begin
            if (base_cnt == '0) begin
                unf_d = 1'b1;
            end else begin
                sp_d    = base_sp - PTR_W'(1);
                count_d = base_cnt - 1'b1;
            end
        end
    end

    // Pointer, count and event pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= PTR_W'(DEPTH - 1);
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage; the later push write wins when both hit one entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (repair_en) mem[ck_sp] <= ck_top;
            if (wr_en)     mem[wr_addr] <= wr_data;
        end
    end

    assign top_o       = mem[sp_q];
    assign top_valid_o = (count_q != '0);
    assign ckpt_o      = {sp_q, count_q, top_o};
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule
